// File: rtl/io_ring_pkg.sv
// Shared definitions for the configurable I/O ring: config field layout,
// chain FSM states and the width derivations used by io_ring and io_chan.
package io_ring_pkg;

  localparam int CFG_OE       = 0;
  localparam int CFG_REG_OUT  = 1;
  localparam int CFG_REG_IN   = 2;
  localparam int CFG_LOOPBACK = 3;
  localparam int CFG_LANE     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } ring_state_e;

  // Lane select width; kept at least one bit so the field exists when CW == W.
  function automatic int lane_bits(input int w, input int cw);
    int ratio;
    ratio = cw / w;
    if (ratio <= 1) return 1;
    return $clog2(ratio);
  endfunction

  function automatic int chan_cfg_bits(input int w, input int cw);
    return 4 + lane_bits(w, cw);
  endfunction

  function automatic int chain_bits(input int nch, input int w, input int cw);
    return nch * chan_cfg_bits(w, cw);
  endfunction

endpackage

// File: rtl/io_chan.sv
// One I/O channel: lane steering between the wide core bus and the pad,
// optional output/input registers and pad loopback.
module io_chan
  import io_ring_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 32,
  parameter int LS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LS+3:0] cfg_i,
  input  logic [W-1:0]  pad_in_i,
  input  logic [CW-1:0] core_out_i,
  output logic [W-1:0]  pad_out_o,
  output logic          pad_oe_o,
  output logic [CW-1:0] core_in_o
);

  localparam int LANES = CW / W;

  logic          oe;
  logic          reg_out;
  logic          reg_in;
  logic          loopback;
  logic [LS-1:0] lane;
  logic [LS-1:0] lane_eff;
  logic [W-1:0]  src;
  logic [W-1:0]  pin;
  logic [W-1:0]  out_q;
  logic [W-1:0]  in_q;

  assign oe       = cfg_i[CFG_OE];
  assign reg_out  = cfg_i[CFG_REG_OUT];
  assign reg_in   = cfg_i[CFG_REG_IN];
  assign loopback = cfg_i[CFG_LOOPBACK];
  assign lane     = cfg_i[CFG_LANE +: LS];

  // Out-of-range lanes (only reachable when there is a single lane) fold to lane 0.
  assign lane_eff = (int'(lane) < LANES) ? lane : '0;

  always_comb begin
    src = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_eff == LS'(l)) src = core_out_i[l*W +: W];
    end
  end

  // in_q serves both the registered input path and the loopback path.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      in_q  <= '0;
    end else begin
      out_q <= src;
      in_q  <= pad_in_i;
    end
  end

  assign pin       = reg_in ? in_q : pad_in_i;
  assign pad_out_o = loopback ? in_q : (reg_out ? out_q : src);
  assign pad_oe_o  = oe | loopback;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign core_in_o[gi*W +: W] = (!loopback && (lane_eff == LS'(gi))) ? pin : '0;
  end

endmodule

// File: rtl/io_ring.sv
// I/O ring top: serial config shadow chain with a length-checked commit FSM,
// plus NCH channel datapaths driven only by the committed (active) config.
module io_ring
  import io_ring_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = 32
) (
  input  logic              clb_clk,
  input  logic              rst,
  input  logic              prog_in,
  input  logic              prog_en,
  output logic              prog_out,
  input  logic [NCH*W-1:0]  pad_in,
  output logic [NCH*W-1:0]  pad_out,
  output logic [NCH-1:0]    pad_oe,
  input  logic [NCH*CW-1:0] core_out,
  output logic [NCH*CW-1:0] core_in,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int LS    = lane_bits(W, CW);
  localparam int CB    = chan_cfg_bits(W, CW);
  localparam int TOTAL = chain_bits(NCH, W, CW);
  localparam int CNTW  = $clog2(TOTAL + 2);

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(TOTAL);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(TOTAL + 1);

  ring_state_e      state_q, state_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_err_q, cfg_err_d;
  logic [TOTAL-1:0] shadow_shifted;

  assign shadow_shifted = {prog_in, shadow_q[TOTAL-1:1]};

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (prog_en) begin
          shadow_d = shadow_shifted;
          cnt_d    = CNT_ONE;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (prog_en) begin
          shadow_d = shadow_shifted;
          cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end else if (cnt_q == CNT_FULL) begin
          state_d = ST_COMMIT;
        end else begin
          // Short or long burst: flag it and keep the previous active config.
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        active_d    = shadow_q;
        cfg_valid_d = 1'b1;
        cfg_err_d   = 1'b0;
        if (prog_en) begin
          shadow_d = shadow_shifted;
          cnt_d    = CNT_ONE;
          state_d  = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clb_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign prog_out  = shadow_q[0];
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    io_chan #(
      .W  (W),
      .CW (CW),
      .LS (LS)
    ) u_chan (
      .clk        (clb_clk),
      .rst        (rst),
      .cfg_i      (active_q[gi*CB +: CB]),
      .pad_in_i   (pad_in[gi*W +: W]),
      .core_out_i (core_out[gi*CW +: CW]),
      .pad_out_o  (pad_out[gi*W +: W]),
      .pad_oe_o   (pad_oe[gi]),
      .core_in_o  (core_in[gi*CW +: CW])
    );
  end

endmodule

// File: tb/tb_io_ring.sv
// Randomized bench for io_ring: a per-channel behavioural model of the
// committed configuration predicts pad and core outputs every cycle.
module tb_io_ring;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int CW    = 32;
  localparam int CB    = 6;
  localparam int TOTAL = 24;

  typedef struct {
    int oe;
    int ro;
    int ri;
    int lb;
    int lane;
  } chan_cfg_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_in;
  logic              prog_en;
  logic              prog_out;
  logic [NCH*W-1:0]  pad_in;
  logic [NCH*W-1:0]  pad_out;
  logic [NCH-1:0]    pad_oe;
  logic [NCH*CW-1:0] core_out;
  logic [NCH*CW-1:0] core_in;
  logic              cfg_valid;
  logic              cfg_err;

  int total = 0;
  int bad   = 0;

  chan_cfg_t         model_cfg[NCH];
  chan_cfg_t         new_cfg[NCH];
  logic              exp_valid;
  logic [NCH*W-1:0]  prev_pad;
  logic [NCH*CW-1:0] prev_core;

  always #5 clk = ~clk;

  io_ring #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clb_clk   (clk),
    .rst       (rst),
    .prog_in   (prog_in),
    .prog_en   (prog_en),
    .prog_out  (prog_out),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .core_out  (core_out),
    .core_in   (core_in),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg();
    for (int c = 0; c < NCH; c++) begin
      new_cfg[c].oe   = int'($urandom_range(0, 1));
      new_cfg[c].ro   = int'($urandom_range(0, 1));
      new_cfg[c].ri   = int'($urandom_range(0, 1));
      new_cfg[c].lb   = int'($urandom_range(0, 1));
      new_cfg[c].lane = int'($urandom_range(0, 3));
    end
  endtask

  task automatic zero_model();
    for (int c = 0; c < NCH; c++) model_cfg[c] = '{0, 0, 0, 0, 0};
  endtask

  // Bit i of the returned word is the i-th bit to shift; upper bits pad long bursts.
  function automatic logic [31:0] pack_new();
    logic [31:0] b;
    int base;
    b = $urandom;
    for (int c = 0; c < NCH; c++) begin
      base = c * CB;
      b[base]     = new_cfg[c].oe[0];
      b[base + 1] = new_cfg[c].ro[0];
      b[base + 2] = new_cfg[c].ri[0];
      b[base + 3] = new_cfg[c].lb[0];
      b[base + 4] = new_cfg[c].lane[0];
      b[base + 5] = new_cfg[c].lane[1];
    end
    return b;
  endfunction

  // Returns in the slot where prog_en has just been dropped.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    $display("burst: %0d bits, word=%h", n, bits);
    for (int i = 0; i < n; i++) begin
      slot();
      prog_en = 1'b1;
      prog_in = bits[i];
    end
    slot();
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  task automatic wait_commit();
    slot();
    slot();
  endtask

  task automatic run_check(input int n, input string tag);
    logic [W-1:0]  exp_po;
    logic          exp_oe;
    logic [CW-1:0] exp_ci;
    logic [W-1:0]  src_now;
    logic [W-1:0]  src_prev;
    logic [W-1:0]  pin;
    int            ln;
    total++;
    if (cfg_valid !== exp_valid) begin
      bad++;
      $display("FAIL %s cfg_valid got=%b exp=%b", tag, cfg_valid, exp_valid);
    end
    for (int i = 0; i < n; i++) begin
      slot();
      prev_pad  = pad_in;
      prev_core = core_out;
      pad_in    = $urandom;
      core_out  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int c = 0; c < NCH; c++) begin
        ln       = (model_cfg[c].lane >= CW / W) ? 0 : model_cfg[c].lane;
        src_now  = core_out[c*CW + ln*W +: W];
        src_prev = prev_core[c*CW + ln*W +: W];
        pin      = (model_cfg[c].ri != 0) ? prev_pad[c*W +: W] : pad_in[c*W +: W];
        exp_oe   = (model_cfg[c].oe != 0) || (model_cfg[c].lb != 0);
        exp_ci   = '0;
        if (model_cfg[c].lb != 0) begin
          exp_po = prev_pad[c*W +: W];
        end else begin
          exp_po = (model_cfg[c].ro != 0) ? src_prev : src_now;
          exp_ci[ln*W +: W] = pin;
        end
        total++;
        if (pad_out[c*W +: W] !== exp_po) begin
          bad++;
          $display("FAIL %s pad_out ch%0d cyc%0d got=%h exp=%h", tag, c, i, pad_out[c*W +: W], exp_po);
        end
        total++;
        if (pad_oe[c] !== exp_oe) begin
          bad++;
          $display("FAIL %s pad_oe ch%0d cyc%0d got=%b exp=%b", tag, c, i, pad_oe[c], exp_oe);
        end
        total++;
        if (core_in[c*CW +: CW] !== exp_ci) begin
          bad++;
          $display("FAIL %s core_in ch%0d cyc%0d got=%h exp=%h", tag, c, i, core_in[c*CW +: CW], exp_ci);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_en = 1'b0; prog_in = 1'b0; pad_in = '0; core_out = '0;
    repeat (3) slot();
    rst = 1'b0;
    repeat (5) slot();
    total++;
    if ({pad_oe, pad_out, core_in, cfg_valid, cfg_err, prog_out} !== '0) begin
      bad++;
      $display("FAIL reset outputs got oe=%h po=%h ci=%h v=%b e=%b po=%b exp all 0",
               pad_oe, pad_out, core_in, cfg_valid, cfg_err, prog_out);
    end
    zero_model();
    exp_valid = 1'b0;
    run_check(8, "reset_default");
  endtask

  task automatic test_basic();
    logic [31:0] bits;
    rand_cfg();
    new_cfg[0] = '{1, 0, 0, 0, 2};
    bits = pack_new();
    core_out[23:16] = 8'hA5;
    pad_in = '0;
    shift_bits(bits, TOTAL);
    total++;
    if (prog_out !== bits[0]) begin
      bad++;
      $display("FAIL prog_out got=%b exp=%b", prog_out, bits[0]);
    end
    slot();
    total++;
    if (pad_oe[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic early_oe got=%b exp=0", pad_oe[0]);
    end
    slot();
    total++;
    if (pad_out[7:0] !== 8'hA5 || pad_oe[0] !== 1'b1 || cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic ch0 got po=%h oe=%b v=%b exp po=a5 oe=1 v=1", pad_out[7:0], pad_oe[0], cfg_valid);
    end
    model_cfg = new_cfg;
    exp_valid = 1'b1;
    run_check(10, "basic");
  endtask

  task automatic test_reg_in();
    rand_cfg();
    new_cfg[1] = '{0, 0, 1, 0, 3};
    shift_bits(pack_new(), TOTAL);
    wait_commit();
    pad_in[15:8] = 8'h3C;
    slot();
    total++;
    if (core_in[63:32] !== 32'h3C00_0000) begin
      bad++;
      $display("FAIL reg_in ch1 core_in got=%h exp=3c000000", core_in[63:32]);
    end
    model_cfg = new_cfg;
    run_check(10, "reg_in");
  endtask

  task automatic test_bad_burst();
    int lens[2] = '{TOTAL - 1, TOTAL + 6};
    for (int k = 0; k < 2; k++) begin
      rand_cfg();
      shift_bits(pack_new(), lens[k]);
      wait_commit();
      total++;
      if (cfg_err !== 1'b1) begin
        bad++;
        $display("FAIL bad_burst len=%0d cfg_err got=%b exp=1", lens[k], cfg_err);
      end
      run_check(6, "bad_burst_hold");
    end
    rand_cfg();
    shift_bits(pack_new(), TOTAL);
    wait_commit();
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL good_after_bad cfg_err got=%b exp=0", cfg_err);
    end
    model_cfg = new_cfg;
    run_check(8, "good_after_bad");
  endtask

  task automatic test_loopback();
    rand_cfg();
    new_cfg[3] = '{0, 1, 0, 1, 1};
    shift_bits(pack_new(), TOTAL);
    wait_commit();
    pad_in[31:24] = 8'h11;
    slot();
    pad_in[31:24] = 8'h22;
    #1;
    total++;
    if (pad_out[31:24] !== 8'h11 || pad_oe[3] !== 1'b1 || core_in[127:96] !== '0) begin
      bad++;
      $display("FAIL loopback step1 got po=%h oe=%b ci=%h exp po=11 oe=1 ci=0", pad_out[31:24], pad_oe[3], core_in[127:96]);
    end
    slot();
    total++;
    if (pad_out[31:24] !== 8'h22) begin
      bad++;
      $display("FAIL loopback step2 got po=%h exp=22", pad_out[31:24]);
    end
    model_cfg = new_cfg;
    run_check(10, "loopback");
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    pad_in = '0;
    core_out = '0;
    rand_cfg();
    bits = pack_new();
    $display("burst: reset at bit 12, word=%h", bits);
    for (int i = 0; i < 12; i++) begin
      slot();
      prog_en = 1'b1;
      prog_in = bits[i];
    end
    slot();
    rst = 1'b1;
    prog_in = bits[12];
    slot();
    rst = 1'b0;
    prog_en = 1'b0;
    prog_in = 1'b0;
    repeat (3) slot();
    total++;
    if ({pad_oe, pad_out, core_in, cfg_valid, cfg_err, prog_out} !== '0) begin
      bad++;
      $display("FAIL reset_mid got oe=%h po=%h ci=%h v=%b e=%b pout=%b exp all 0",
               pad_oe, pad_out, core_in, cfg_valid, cfg_err, prog_out);
    end
    zero_model();
    exp_valid = 1'b0;
    run_check(4, "reset_mid_zero");
    rand_cfg();
    shift_bits(pack_new(), TOTAL);
    wait_commit();
    model_cfg = new_cfg;
    exp_valid = 1'b1;
    run_check(8, "after_reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits;
    rand_cfg();
    shift_bits(pack_new(), TOTAL);
    rand_cfg();
    bits = pack_new();
    shift_bits(bits, TOTAL);
    total++;
    if (prog_out !== bits[0]) begin
      bad++;
      $display("FAIL b2b prog_out got=%b exp=%b", prog_out, bits[0]);
    end
    wait_commit();
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b cfg_err got=%b exp=0", cfg_err);
    end
    model_cfg = new_cfg;
    run_check(10, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg_in();
    test_bad_burst();
    test_loopback();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_ring.md
IO_RING -- requirements
Module: io_ring

Interface
REQ-001 Parameter NCH, default 4: number of I/O channels.
REQ-002 Parameter W, default 8: pad width per channel.
REQ-003 Parameter CW, default 32: core-side width per channel; CW/W is a power of two, at least 1.
REQ-004 Derived: LS = max(1, clog2(CW/W)); CB = 4+LS config bits per channel; TOTAL = NCH*CB chain bits.
REQ-005 clb_clk  in  1  sole clock for config shift and datapath.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 prog_in  in  1  serial config data.
REQ-008 prog_en  in  1  shift enable; high = shift one bit per cycle.
REQ-009 prog_out  out  1  chain output (shadow[0]) for daisy-chaining.
REQ-010 pad_in  in  NCH*W  pad input data; channel c = [c*W +: W].
REQ-011 pad_out  out  NCH*W  pad output data.
REQ-012 pad_oe  out  NCH  per-channel pad output enable.
REQ-013 core_out  in  NCH*CW  core-to-pad data; channel c = [c*CW +: CW].
REQ-014 core_in  out  NCH*CW  pad-to-core data.
REQ-015 cfg_valid  out  1  a configuration has been committed since reset.
REQ-016 cfg_err  out  1  last shift burst had the wrong bit count.

Function
REQ-017 Shadow chain TOTAL bits; each shift cycle shadow <= {prog_in, shadow[TOTAL-1:1]}; the first bit shifted lands in shadow[0] after TOTAL shifts.
REQ-018 Channel c fields, in shadow/active[c*CB +: CB]: bit0 oe, bit1 reg_out, bit2 reg_in, bit3 loopback, bits[4 +: LS] lane.
REQ-019 FSM states IDLE, SHIFT, COMMIT; cnt register width clog2(TOTAL+2), saturating at TOTAL+1.
REQ-020 IDLE & prog_en: shift, cnt=1, go to SHIFT. IDLE & !prog_en: hold.
REQ-021 SHIFT & prog_en: shift, cnt++ (saturating).
REQ-022 SHIFT & !prog_en & cnt==TOTAL: go to COMMIT. SHIFT & !prog_en & cnt!=TOTAL: cfg_err<=1, active unchanged, go to IDLE.
REQ-023 COMMIT: active<=shadow, cfg_valid<=1, cfg_err<=0. Exit to SHIFT with shift and cnt=1 if prog_en is high, else to IDLE.
REQ-024 The datapath uses only the active config; shifting never disturbs pad_out, pad_oe or core_in until commit.
REQ-025 New config takes effect on the cycle after COMMIT (pad paths see active one cycle after prog_en falls + 1).
REQ-026 Normal output: src = core_out lane `lane` of channel, i.e. [c*CW + lane*W +: W]; pad_out = src combinational if reg_out=0, else src delayed one cycle.
REQ-027 pad_oe[c] = oe | loopback.
REQ-028 Normal input: pin = pad_in (reg_in=0) or pad_in delayed one cycle (reg_in=1); pin is placed in core_in lane `lane`, and all other lanes of the channel are 0.
REQ-029 Loopback=1: pad_out = pad_in delayed exactly one cycle, regardless of reg_out; core_in of the channel is all 0.
REQ-030 lane values >= CW/W (only possible when CW==W with LS=1) are treated as lane 0.
REQ-031 All datapath registers update every cycle regardless of FSM state.

Reset
REQ-032 rst: shadow=0, active=0, state=IDLE, cnt=0, cfg_valid=0, cfg_err=0, all data registers=0.
REQ-033 After reset: prog_out=0, pad_oe=0, pad_out=0, core_in=0; rst has priority over prog_en at the same edge.
REQ-034 rst mid-shift: the burst is discarded, no commit occurs, and cfg_err stays 0.

Structure
REQ-035 Package io_ring_pkg holds the channel config field offsets, the FSM state enum, and the CB/TOTAL derivation functions.
REQ-036 One sub-module io_chan (a single channel's mux, lane steering and registers) is generated NCH times; the FSM and chain live in top-level io_ring.

Verification (NCH=4, W=8, CW=32, so CB=6, TOTAL=24)
REQ-037 Reset, then idle 5 cycles -> pad_oe=0, pad_out=0, core_in=0, cfg_valid=0, cfg_err=0.
REQ-038 Shift 24 bits setting ch0 oe=1, lane=2, reg_out=0, and core_out ch0 lane2=0xA5 -> pad_out[7:0]=0xA5, pad_oe[0]=1 from the 2nd cycle after prog_en falls; cfg_valid=1.
REQ-039 Set ch1 reg_in=1, lane=3, pad_in ch1=0x3C -> core_in[63:56]=0x3C one cycle later, other ch1 lanes 0.
REQ-040 Shift 23 bits -> cfg_err=1, outputs unchanged; then shift a correct 24-bit burst -> cfg_err=0.
REQ-041 Set ch3 loopback=1 and step pad_in ch3 0x11, 0x22 -> pad_out ch3 follows one cycle later, pad_oe[3]=1, core_in ch3=0.
REQ-042 Assert rst at shift bit 12 -> active=0 and all outputs 0; the next full burst commits normally.
